// File: rtl/frame_deframer.sv
// frame_deframer
// Recovers framed packets from the CDR bit stream. Hunts for SYNC_WORD,
// then deserialises a LEN byte, LEN payload bytes and a CRC-8 byte, and
// reports the payload and the CRC verdict to the packet layer.
//
// Ports
//   clk_x8     : oversampling clock (CDR domain)
//   rst_n      : asynchronous active-low reset
//   bit_in     : recovered data bit
//   bit_valid  : one-cycle strobe, bit_in carries a new bit
//   data_out   : payload byte, MSB = first received bit
//   data_valid : one-cycle strobe, data_out valid
//   sof / eof  : first / last payload byte markers (with data_valid)
//   frame_done : one-cycle pulse after the CRC byte
//   crc_ok     : CRC verdict of the last frame, held until next frame_done
//   len_err    : one-cycle pulse when LEN exceeds MAX_LEN
//   locked     : high from sync detection until frame_done or len_err
module frame_deframer #(
  parameter logic [15:0] SYNC_WORD = 16'hA5C3,
  parameter int unsigned MAX_LEN   = 64
) (
  input  logic       clk_x8,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       sof,
  output logic       eof,
  output logic       frame_done,
  output logic       crc_ok,
  output logic       len_err,
  output logic       locked
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } state_t;

  // One bit of the CRC-8 (poly 0x07) shift update, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] sr_r, sr_shift_s;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  byte_cnt_r, crc_r, crc_step_s, byte_s;
  logic        first_r;
  logic        last_bit_s, sync_hit_s, len_bad_s;

  logic [7:0]  data_out_r, data_out_nxt_s;
  logic        data_valid_r, data_valid_nxt_s;
  logic        sof_r, sof_nxt_s, eof_r, eof_nxt_s;
  logic        frame_done_r, frame_done_nxt_s;
  logic        crc_ok_r, crc_ok_nxt_s;
  logic        len_err_r, len_err_nxt_s;
  logic        locked_r, locked_nxt_s;

  // The completed byte is always the low 8 bits of the post-shift register.
  assign sr_shift_s = {sr_r[14:0], bit_in};
  assign byte_s     = sr_shift_s[7:0];
  assign last_bit_s = bit_valid && (bit_cnt_r == 3'd7);
  assign sync_hit_s = bit_valid && (state_r == ST_HUNT) && (sr_shift_s == SYNC_WORD);
  assign len_bad_s  = (byte_s > MAX_LEN_B);
  assign crc_step_s = crc8_step(crc_r, bit_in);

  // State register.
  always_ff @(posedge clk_x8 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_HUNT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; transitions only on the bit that completes a field.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HUNT: begin
        if (sync_hit_s) state_nxt_s = ST_LEN;
        else            state_nxt_s = ST_HUNT;
      end
      ST_LEN: begin
        if (!last_bit_s)           state_nxt_s = ST_LEN;
        else if (len_bad_s)        state_nxt_s = ST_HUNT;
        else if (byte_s == 8'h00)  state_nxt_s = ST_CRC;
        else                       state_nxt_s = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (last_bit_s && (byte_cnt_r == 8'd1)) state_nxt_s = ST_CRC;
        else                                    state_nxt_s = ST_PAYLOAD;
      end
      ST_CRC: begin
        if (last_bit_s) state_nxt_s = ST_HUNT;
        else            state_nxt_s = ST_CRC;
      end
      default: state_nxt_s = ST_HUNT;
    endcase
  end

  // Output decode: next values of the registered outputs; strobes default low.
  always_comb begin
    data_out_nxt_s   = data_out_r;
    data_valid_nxt_s = 1'b0;
    sof_nxt_s        = 1'b0;
    eof_nxt_s        = 1'b0;
    frame_done_nxt_s = 1'b0;
    crc_ok_nxt_s     = crc_ok_r;
    len_err_nxt_s    = 1'b0;
    locked_nxt_s     = locked_r;
    case (state_r)
      ST_HUNT: begin
        if (sync_hit_s) locked_nxt_s = 1'b1;
        else            locked_nxt_s = locked_r;
      end
      ST_LEN: begin
        if (last_bit_s && len_bad_s) begin
          len_err_nxt_s = 1'b1;
          locked_nxt_s  = 1'b0;
        end else begin
          locked_nxt_s  = locked_r;
        end
      end
      ST_PAYLOAD: begin
        if (last_bit_s) begin
          data_out_nxt_s   = byte_s;
          data_valid_nxt_s = 1'b1;
          sof_nxt_s        = first_r;
          eof_nxt_s        = (byte_cnt_r == 8'd1);
        end else begin
          data_out_nxt_s   = data_out_r;
        end
      end
      ST_CRC: begin
        // crc_r is frozen during the CRC byte, so it holds the frame CRC.
        if (last_bit_s) begin
          frame_done_nxt_s = 1'b1;
          crc_ok_nxt_s     = (byte_s == crc_r);
          locked_nxt_s     = 1'b0;
        end else begin
          crc_ok_nxt_s     = crc_ok_r;
        end
      end
      default: locked_nxt_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_x8 or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r   <= 8'h00;
      data_valid_r <= 1'b0;
      sof_r        <= 1'b0;
      eof_r        <= 1'b0;
      frame_done_r <= 1'b0;
      crc_ok_r     <= 1'b0;
      len_err_r    <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      data_out_r   <= data_out_nxt_s;
      data_valid_r <= data_valid_nxt_s;
      sof_r        <= sof_nxt_s;
      eof_r        <= eof_nxt_s;
      frame_done_r <= frame_done_nxt_s;
      crc_ok_r     <= crc_ok_nxt_s;
      len_err_r    <= len_err_nxt_s;
      locked_r     <= locked_nxt_s;
    end
  end

  // Datapath: shift register, bit/byte counters, running CRC.
  always_ff @(posedge clk_x8 or negedge rst_n) begin
    if (!rst_n) begin
      sr_r       <= 16'h0000;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 8'd0;
      crc_r      <= 8'h00;
      first_r    <= 1'b0;
    end else if (bit_valid) begin
      case (state_r)
        ST_HUNT: begin
          // CRC and bit count sit at zero so a sync hit starts a clean frame.
          sr_r      <= sr_shift_s;
          bit_cnt_r <= 3'd0;
          crc_r     <= 8'h00;
        end
        ST_LEN: begin
          bit_cnt_r <= bit_cnt_r + 3'd1;
          crc_r     <= crc_step_s;
          if (last_bit_s && len_bad_s) begin
            sr_r <= 16'h0000;
          end else if (last_bit_s) begin
            sr_r       <= sr_shift_s;
            byte_cnt_r <= byte_s;
            first_r    <= 1'b1;
          end else begin
            sr_r <= sr_shift_s;
          end
        end
        ST_PAYLOAD: begin
          sr_r      <= sr_shift_s;
          bit_cnt_r <= bit_cnt_r + 3'd1;
          crc_r     <= crc_step_s;
          if (last_bit_s) begin
            first_r <= 1'b0;
            if (byte_cnt_r != 8'd0) byte_cnt_r <= byte_cnt_r - 8'd1;
            else                    byte_cnt_r <= 8'd0;
          end else begin
            first_r <= first_r;
          end
        end
        ST_CRC: begin
          // Clearing sr lets a sync word starting on the next bit be found.
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (last_bit_s) sr_r <= 16'h0000;
          else            sr_r <= sr_shift_s;
        end
        default: begin
          sr_r      <= 16'h0000;
          bit_cnt_r <= 3'd0;
        end
      endcase
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign sof        = sof_r;
  assign eof        = eof_r;
  assign frame_done = frame_done_r;
  assign crc_ok     = crc_ok_r;
  assign len_err    = len_err_r;
  assign locked     = locked_r;

endmodule

// File: tb/tb_frame_deframer.sv
// Testbench for frame_deframer: directed frames from the test plan plus
// randomized frames, checked against a byte-level frame model.
module tb_frame_deframer;

  localparam int          MAX_LEN = 64;
  localparam logic [15:0] SYNC    = 16'hA5C3;

  logic       clk_x8 = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, sof, eof, frame_done, crc_ok, len_err, locked;

  int n_tests = 0;
  int n_fail  = 0;

  // kind: 0 = payload byte, 1 = frame_done, 2 = len_err
  typedef struct packed {
    logic [1:0] kind;
    logic [9:0] val;
  } ev_t;
  ev_t exp_q[$];

  frame_deframer #(.SYNC_WORD(SYNC), .MAX_LEN(MAX_LEN)) dut (
    .clk_x8(clk_x8), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(data_out), .data_valid(data_valid), .sof(sof), .eof(eof),
    .frame_done(frame_done), .crc_ok(crc_ok), .len_err(len_err), .locked(locked)
  );

  always #5 clk_x8 = ~clk_x8;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte-wise CRC-8 (poly 0x07, init 0, no reflection, no final XOR).
  function automatic logic [7:0] ref_crc(input logic [7:0] bytes[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (bytes[i]) begin
      c = c ^ bytes[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // True when noise followed by SYNC matches SYNC only at the very end
  // (the deframer's window starts from all zeros).
  function automatic bit sync_only_at_end(input logic nb[$]);
    logic [15:0] w;
    logic        b;
    int          total;
    w = 16'h0000;
    total = nb.size() + 16;
    for (int i = 0; i < total; i++) begin
      b = (i < nb.size()) ? nb[i] : SYNC[15 - (i - nb.size())];
      w = {w[14:0], b};
      if (w == SYNC && i != total - 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Every strobe seen must match the head of the expected-event queue.
  always @(negedge clk_x8) begin
    ev_t got, want;
    if (data_valid || frame_done || len_err) begin
      check_eq("single_strobe", 32'(data_valid) + 32'(frame_done) + 32'(len_err), 32'd1);
      if (data_valid)      got = '{kind: 2'd0, val: {sof, eof, data_out}};
      else if (frame_done) got = '{kind: 2'd1, val: 10'(crc_ok)};
      else                 got = '{kind: 2'd2, val: 10'(locked)};
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", 32'(got), 32'hFFFF_FFFF);
      end else begin
        want = exp_q.pop_front();
        check_eq("event_kind", 32'(got.kind), 32'(want.kind));
        check_eq("event_value", 32'(got.val), 32'(want.val));
      end
    end
    if (!data_valid && (sof || eof)) check_eq("sof_eof_idle", 32'({sof, eof}), 32'd0);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_x8);
  endtask

  // Drive one bit for one cycle; returns at the negedge where its result shows.
  task automatic send_bit(input logic b);
    @(negedge clk_x8);
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk_x8);
    bit_valid = 1'b0;
    bit_in    = 1'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(v[i]);
      if (i != 0) idle(gap);
    end
  endtask

  task automatic send_frame(input logic [7:0] len_b, input logic [7:0] pl[$],
                            input logic [7:0] crc_b, input int gap, input int noise_n);
    logic [7:0] body[$];
    logic       nb[$];
    logic       exp_ok;
    do begin
      nb.delete();
      for (int i = 0; i < noise_n; i++) nb.push_back(1'($urandom));
    end while (!sync_only_at_end(nb));

    exp_ok = 1'b0;
    if (32'(len_b) > MAX_LEN) begin
      exp_q.push_back('{kind: 2'd2, val: 10'd0});
    end else begin
      body.push_back(len_b);
      foreach (pl[i]) begin
        body.push_back(pl[i]);
        exp_q.push_back('{kind: 2'd0, val: {(i == 0), (i == pl.size() - 1), pl[i]}});
      end
      exp_ok = (crc_b == ref_crc(body));
      exp_q.push_back('{kind: 2'd1, val: 10'(exp_ok)});
    end

    foreach (nb[i]) begin
      send_bit(nb[i]);
      idle(gap);
    end
    for (int i = 15; i >= 0; i--) begin
      send_bit(SYNC[i]);
      if (i != 0) idle(gap);
    end
    check_eq("locked_after_sync", 32'(locked), 32'd1);
    idle(gap);

    send_byte(len_b, gap);
    if (32'(len_b) > MAX_LEN) begin
      check_eq("len_err_latency", 32'(len_err), 32'd1);
      check_eq("unlocked_len_err", 32'(locked), 32'd0);
    end else begin
      idle(gap);
      foreach (pl[i]) begin
        send_byte(pl[i], gap);
        check_eq("data_valid_latency", 32'(data_valid), 32'd1);
        idle(gap);
      end
      send_byte(crc_b, gap);
      check_eq("frame_done_latency", 32'(frame_done), 32'd1);
      check_eq("crc_ok", 32'(crc_ok), 32'(exp_ok));
      check_eq("unlocked_frame_done", 32'(locked), 32'd0);
    end
    idle(3);
    check_eq("events_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Random payload of the given length, correct or deliberately corrupt CRC.
  task automatic random_frame(input int len, input bit bad, input int gap, input int noise_n);
    logic [7:0] pl[$];
    logic [7:0] body[$];
    logic [7:0] c;
    body.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      pl.push_back(8'($urandom));
      body.push_back(pl[i]);
    end
    c = ref_crc(body);
    if (bad) c = c ^ 8'(1 << $urandom_range(0, 7));
    send_frame(8'(len), pl, c, gap, noise_n);
  endtask

  initial begin
    logic [7:0] pl[$];
    int         len;

    rst_n = 1'b0;
    idle(3);
    check_eq("reset_outputs",
             32'({data_out, data_valid, sof, eof, frame_done, crc_ok, len_err, locked}), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Known-good frame 02 12 34 / 27, then the same with a wrong CRC.
    pl = '{8'h12, 8'h34};
    send_frame(8'h02, pl, 8'h27, 0, 0);
    send_frame(8'h02, pl, 8'h26, 1, 0);

    // Empty frame.
    pl.delete();
    send_frame(8'h00, pl, 8'h00, 0, 0);

    // Oversize LEN, then a good frame must still decode.
    send_frame(8'h41, pl, 8'h00, 0, 0);
    random_frame(5, 1'b0, 0, 4);

    // Noise, long bit_valid gaps, sync pattern embedded in payload.
    pl = '{8'hA5, 8'hC3, 8'h3C};
    begin
      logic [7:0] body[$];
      body = '{8'h03, 8'hA5, 8'hC3, 8'h3C};
      send_frame(8'h03, pl, ref_crc(body), 7, 20);
    end

    // Boundary lengths.
    random_frame(MAX_LEN, 1'b0, 0, 0);
    random_frame(1, 1'b0, 2, 3);
    pl.delete();
    send_frame(8'hFF, pl, 8'h00, 0, 5);

    // Reset during the second payload byte.
    exp_q.push_back('{kind: 2'd0, val: {1'b1, 1'b0, 8'h5A}});
    for (int i = 15; i >= 0; i--) send_bit(SYNC[i]);
    send_byte(8'h03, 0);
    send_byte(8'h5A, 1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset_outputs",
                32'({data_out, data_valid, sof, eof, frame_done, crc_ok, len_err, locked}), 32'd0);
    check_eq("events_before_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    idle(3);
    rst_n = 1'b1;
    idle(4);
    random_frame(4, 1'b0, 1, 6);

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, 24);
      random_frame(len, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), $urandom_range(0, 12));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
